// File: rtl/eight_point_fft_pkg.sv
// rtl/eight_point_fft_pkg.sv - constants, twiddle LUT and FSM states for eight_point_fft
package eight_point_fft_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;
    localparam int PROD_W = 2 * DATA_W;
    localparam int ACC_W  = 36;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    function automatic logic signed [DATA_W-1:0] tw_cos(input logic [2:0] m);
        case (m)
            3'd0:    tw_cos = 16'sd256;
            3'd1:    tw_cos = 16'sd181;
            3'd2:    tw_cos = 16'sd0;
            3'd3:    tw_cos = -16'sd181;
            3'd4:    tw_cos = -16'sd256;
            3'd5:    tw_cos = -16'sd181;
            3'd6:    tw_cos = 16'sd0;
            default: tw_cos = 16'sd181;
        endcase
    endfunction

    function automatic logic signed [DATA_W-1:0] tw_sin(input logic [2:0] m);
        case (m)
            3'd0:    tw_sin = 16'sd0;
            3'd1:    tw_sin = 16'sd181;
            3'd2:    tw_sin = 16'sd256;
            3'd3:    tw_sin = 16'sd181;
            3'd4:    tw_sin = 16'sd0;
            3'd5:    tw_sin = -16'sd181;
            3'd6:    tw_sin = -16'sd256;
            default: tw_sin = -16'sd181;
        endcase
    endfunction

endpackage

// File: rtl/eight_point_fft_cmul.sv
// rtl/eight_point_fft_cmul.sv - combinational 16x16 complex multiplier, Q16.16 products
module fft_cmul
    import eight_point_fft_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic signed [DATA_W-1:0] c,
    input  logic signed [DATA_W-1:0] d,
    output logic signed [PROD_W-1:0] re,
    output logic signed [PROD_W-1:0] im
);

    logic signed [PROD_W-1:0] ac, bd, ad, bc;

    assign ac = a * c;
    assign bd = b * d;
    assign ad = a * d;
    assign bc = b * c;
    assign re = ac - bd;
    assign im = ad + bc;

endmodule

// File: rtl/eight_point_fft.sv
// rtl/eight_point_fft.sv - sequential 8-point DFT, one shared complex MAC (FFT_SATURATE_EN selects clamping)
module eight_point_fft
    import eight_point_fft_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic signed [DATA_W-1:0] in0_real, in1_real, in2_real, in3_real,
    input  logic signed [DATA_W-1:0] in4_real, in5_real, in6_real, in7_real,
    input  logic signed [DATA_W-1:0] in0_imag, in1_imag, in2_imag, in3_imag,
    input  logic signed [DATA_W-1:0] in4_imag, in5_imag, in6_imag, in7_imag,
    input  logic                     write,
    input  logic                     start,
    output logic signed [DATA_W-1:0] out0_real, out1_real, out2_real, out3_real,
    output logic signed [DATA_W-1:0] out4_real, out5_real, out6_real, out7_real,
    output logic signed [DATA_W-1:0] out0_imag, out1_imag, out2_imag, out3_imag,
    output logic signed [DATA_W-1:0] out4_imag, out5_imag, out6_imag, out7_imag,
    output logic                     ready
);

    logic signed [DATA_W-1:0] in_re [8];
    logic signed [DATA_W-1:0] in_im [8];
    logic signed [DATA_W-1:0] x_re  [8];
    logic signed [DATA_W-1:0] x_im  [8];
    logic signed [DATA_W-1:0] o_re  [8];
    logic signed [DATA_W-1:0] o_im  [8];

    assign in_re = '{in0_real, in1_real, in2_real, in3_real, in4_real, in5_real, in6_real, in7_real};
    assign in_im = '{in0_imag, in1_imag, in2_imag, in3_imag, in4_imag, in5_imag, in6_imag, in7_imag};

    assign {out0_real, out1_real, out2_real, out3_real} = {o_re[0], o_re[1], o_re[2], o_re[3]};
    assign {out4_real, out5_real, out6_real, out7_real} = {o_re[4], o_re[5], o_re[6], o_re[7]};
    assign {out0_imag, out1_imag, out2_imag, out3_imag} = {o_im[0], o_im[1], o_im[2], o_im[3]};
    assign {out4_imag, out5_imag, out6_imag, out7_imag} = {o_im[4], o_im[5], o_im[6], o_im[7]};

    state_t                   state;
    logic [5:0]               cnt;
    logic [2:0]               k, n, m;
    logic signed [ACC_W-1:0]  acc_re, acc_im, sum_re, sum_im;
    logic signed [DATA_W-1:0] tw_re, tw_im;
    logic signed [PROD_W-1:0] prod_re, prod_im;

    assign k = cnt[5:3];
    assign n = cnt[2:0];
    assign m = n * k;
    assign tw_re = tw_cos(m);
    // W^m = cos - j*sin, so the imaginary twiddle part is the negated sine
    assign tw_im = -tw_sin(m);

    fft_cmul u_cmul (
        .a  (x_re[n]),
        .b  (x_im[n]),
        .c  (tw_re),
        .d  (tw_im),
        .re (prod_re),
        .im (prod_im)
    );

    assign sum_re = acc_re + ACC_W'(prod_re);
    assign sum_im = acc_im + ACC_W'(prod_im);

    function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = (v + ACC_W'(128)) >>> FRAC_W;
`ifdef FFT_SATURATE_EN
        if (r > ACC_W'(32767))
            scale = 16'sh7FFF;
        else if (r < -ACC_W'(32768))
            scale = 16'sh8000;
        else
            scale = r[DATA_W-1:0];
`else
        scale = r[DATA_W-1:0];
`endif
    endfunction

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            state  <= IDLE;
            cnt    <= '0;
            acc_re <= '0;
            acc_im <= '0;
            ready  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                x_re[i] <= '0;
                x_im[i] <= '0;
                o_re[i] <= '0;
                o_im[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (write) begin
                        x_re <= in_re;
                        x_im <= in_im;
                    end
                    if (start) begin
                        state  <= BUSY;
                        cnt    <= '0;
                        acc_re <= '0;
                        acc_im <= '0;
                    end
                end
                BUSY: begin
                    if (n == 3'd7) begin
                        o_re[k] <= scale(sum_re);
                        o_im[k] <= scale(sum_im);
                        acc_re  <= '0;
                        acc_im  <= '0;
                    end else begin
                        acc_re <= sum_re;
                        acc_im <= sum_im;
                    end
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd63) begin
                        state <= DONE;
                        ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (write) begin
                        x_re <= in_re;
                        x_im <= in_im;
                    end
                    if (!start) begin
                        state <= IDLE;
                        ready <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eight_point_fft.sv
// tb/tb_eight_point_fft.sv - directed vector bench for eight_point_fft
module tb_eight_point_fft;

    typedef struct packed {
        logic [7:0][15:0] xr;
        logic [7:0][15:0] xi;
        logic [7:0][15:0] er;
        logic [7:0][15:0] ei;
    } vec_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic        write = 1'b0;
    logic        start = 1'b0;
    logic        ready;
    logic [15:0] i_re [8];
    logic [15:0] i_im [8];
    logic [15:0] o_re [8];
    logic [15:0] o_im [8];

    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs [5];

    always #5 CLK = ~CLK;

    eight_point_fft dut (
        .CLK(CLK), .RST_N(RST_N),
        .in0_real(i_re[0]), .in1_real(i_re[1]), .in2_real(i_re[2]), .in3_real(i_re[3]),
        .in4_real(i_re[4]), .in5_real(i_re[5]), .in6_real(i_re[6]), .in7_real(i_re[7]),
        .in0_imag(i_im[0]), .in1_imag(i_im[1]), .in2_imag(i_im[2]), .in3_imag(i_im[3]),
        .in4_imag(i_im[4]), .in5_imag(i_im[5]), .in6_imag(i_im[6]), .in7_imag(i_im[7]),
        .write(write), .start(start),
        .out0_real(o_re[0]), .out1_real(o_re[1]), .out2_real(o_re[2]), .out3_real(o_re[3]),
        .out4_real(o_re[4]), .out5_real(o_re[5]), .out6_real(o_re[6]), .out7_real(o_re[7]),
        .out0_imag(o_im[0]), .out1_imag(o_im[1]), .out2_imag(o_im[2]), .out3_imag(o_im[3]),
        .out4_imag(o_im[4]), .out5_imag(o_im[5]), .out6_imag(o_im[6]), .out7_imag(o_im[7]),
        .ready(ready)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            i_re[i] = v.xr[i];
            i_im[i] = v.xi[i];
        end
    endtask

    task automatic wait_ready(input string nm, input int exp_lat);
        int lat;
        lat = 0;
        while (!ready && lat < 100) begin
            tick();
            lat++;
        end
        chk(nm, 0, 16'(lat), 16'(exp_lat));
    endtask

    task automatic cmp_outs(input string nm, input vec_t v);
        for (int i = 0; i < 8; i++) begin
            chk({nm, "_re"}, i, o_re[i], v.er[i]);
            chk({nm, "_im"}, i, o_im[i], v.ei[i]);
        end
    endtask

    task automatic launch(input vec_t v);
        drive(v);
        write = 1'b1;
        start = 1'b1;
        tick();
        write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            i_re[i] = '0;
            i_im[i] = '0;
        end
        vecs[0] = '0; vecs[1] = '0; vecs[2] = '0; vecs[3] = '0; vecs[4] = '0;
        for (int i = 0; i < 8; i++) begin
            vecs[0].xr[i] = 16'(i << 8);
            vecs[1].xr[i] = 16'((i + 1) << 8);
            vecs[2].xr[i] = 16'((i + 1) << 8);
            vecs[2].xi[i] = 16'((i + 1) << 8);
            vecs[3].xr[i] = 16'h7F00;
        end
        vecs[4].xr[1] = 16'h0001;
        vecs[0].er = {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'h1C00};
        vecs[0].ei = {16'hF658, 16'hFC00, 16'hFE58, 16'h0000, 16'h01A8, 16'h0400, 16'h09A8, 16'h0000};
        vecs[1].er = {16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00, 16'h2400};
        vecs[1].ei = vecs[0].ei;
        vecs[2].er = {16'h05A8, 16'h0000, 16'hFDA8, 16'hFC00, 16'hFA58, 16'hF800, 16'hF258, 16'h2400};
        vecs[2].ei = {16'hF258, 16'hF800, 16'hFA58, 16'hFC00, 16'hFDA8, 16'h0000, 16'h05A8, 16'h2400};
`ifdef FFT_SATURATE_EN
        vecs[3].er[0] = 16'h7FFF;
`else
        vecs[3].er[0] = 16'hF800;
`endif
        vecs[4].er = {16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h0001};
        vecs[4].ei = {16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};

        // Reset with start held: nothing may launch
        RST_N = 1'b1;
        start = 1'b1;
        tick();
        tick();
        chk("rst_ready", 0, 16'(ready), 16'h0);
        for (int i = 0; i < 8; i++) begin
            chk("rst_re", i, o_re[i], 16'h0);
            chk("rst_im", i, o_im[i], 16'h0);
        end
        RST_N = 1'b0;
        start = 1'b0;
        tick();
        chk("post_rst_ready", 0, 16'(ready), 16'h0);

        for (int v = 0; v < 5; v++) begin
            launch(vecs[v]);
            wait_ready("latency", 64);
            cmp_outs($sformatf("vec%0d", v), vecs[v]);
            start = 1'b0;
            tick();
            chk("ready_fall", v, 16'(ready), 16'h0);
        end

        // write during BUSY must not disturb captured samples
        launch(vecs[0]);
        repeat (10) tick();
        drive(vecs[3]);
        write = 1'b1;
        tick();
        write = 1'b0;
        wait_ready("busy_write_lat", 53);
        cmp_outs("busy_write", vecs[0]);

        // DONE held while start high, then deassert/reassert
        tick();
        tick();
        chk("done_hold", 0, 16'(ready), 16'h1);
        start = 1'b0;
        tick();
        chk("done_drop", 0, 16'(ready), 16'h0);
        start = 1'b1;
        tick();
        wait_ready("relaunch_lat", 64);
        chk("relaunch_x0", 0, o_re[0], 16'h1C00);
        start = 1'b0;
        tick();

        // Reset 30 cycles into a transform aborts it
        launch(vecs[1]);
        repeat (30) tick();
        RST_N = 1'b1;
        tick();
        RST_N = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("abort_re", i, o_re[i], 16'h0);
            chk("abort_im", i, o_im[i], 16'h0);
        end
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 70; c++) begin
                tick();
                if (ready) seen++;
            end
            chk("abort_ready", 0, 16'(seen), 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eight_point_fft.md
# eight_point_fft

Sequential 8-point complex DFT engine computed by direct multiplication. It computes X[k] = Σ x[n]·W^(nk), with W = e^(−j2π/8), for k, n = 0..7. Eight complex Q8.8 samples are loaded in parallel, processed by one shared complex multiply-accumulate over 64 cycles, and presented as eight parallel complex Q8.8 results with a ready flag. It sits between a parallel sample source and downstream spectral logic.

## Interface
Parameters:
- DATA_W, 16, sample/result width (signed two's complement, Q8.8, 1.0 = 0x0100)
- FRAC_W, 8, fractional bits of samples and twiddles

Ports:
- CLK  in  1  sole clock, rising-edge
- RST_N  in  1  reset; synchronous, active-high (asserted = 1, despite the name)
- in0_real … in7_real, in0_imag … in7_imag  in  16 each  input samples x[0..7], signed Q8.8
- write  in  1  capture all 16 input words into internal sample registers
- start  in  1  launch a transform (level-sampled)
- out0_real … out7_real, out0_imag … out7_imag  out  16 each  results X[0..7], signed Q8.8, registered
- ready  out  1  results valid

## Operation
- Twiddle LUT, Q8.8, m = (n·k) mod 8: cos = 256, 181, 0, −181, −256, −181, 0, 181; W^m = cos(2πm/8) − j·sin(2πm/8); sin = 0, 181, 256, 181, 0, −181, −256, −181.
- Complex product: re = a·c − b·d, im = a·d + b·c. Products are 32-bit signed Q16.16. Accumulator is 36-bit signed per component.
- Result scaling: (acc + 0x80) >>> 8 (round half up), then reduced to 16 bits (see Configuration).
- FSM states:
  - IDLE: start=1 → BUSY with cnt=0 and acc cleared.
  - BUSY: each cycle processes k = cnt[5:3], n = cnt[2:0]. When n = 7, acc + product is scaled into out[k] and acc is cleared; otherwise acc += product. After cnt = 63 → DONE.
  - DONE: ready=1. start=0 → IDLE (ready=0).
- write is accepted in IDLE and DONE. It is ignored in BUSY, so the sample registers stay stable during a transform.
- write and start high in the same IDLE cycle: the new samples are captured and used by the launched transform.
- While start is held high, DONE is held; there is no automatic re-run.
- Outputs update progressively during BUSY and are valid only while ready=1.

## Timing
- Reset (RST_N=1 at a clock edge) forces:
  - all outputs and sample registers to 0
  - ready = 0
  - FSM to IDLE
- Reset mid-BUSY aborts the transform.
- Latency: start sampled at edge E0 → BUSY from E0. The 64 MAC edges are E1..E64. ready=1 is visible after E64.
- ready falls one edge after start is sampled low in DONE.
- Throughput: one transform per ≥66 cycles.

## Configuration
- FFT_SATURATE_EN defined: a scaled result outside [−32768, 32767] clamps to 0x8000 or 0x7FFF.
- FFT_SATURATE_EN undefined: the low 16 bits are kept (wrap-around).

## Structure
- Package eight_point_fft_pkg holds:
  - DATA_W and FRAC_W constants
  - the 8-entry cos/sin twiddle LUT
  - the FSM state enum (IDLE, BUSY, DONE)
- One sub-module, fft_cmul: combinational 16×16 complex multiplier producing 32-bit re/im.
- Top level holds the sample registers, counter, accumulator, output registers and FSM.

## Test plan
- Reset: assert RST_N=1 for 2 cycles → all outputs 0x0000, ready=0. Hold start=1 during reset → no transform starts.
- Ramp 0..7 real (0x0000, 0x0100 … 0x0700), write then start → after 64 cycles ready=1 and:
  - X0 = 0x1C00 + j0
  - X1 = 0xFC00 + j0x09A8
  - X2 = 0xFC00 + j0x0400
  - X4 = 0xFC00 + j0
  - X6 = 0xFC00 + j0xFC00
  - X7 = 0xFC00 + j0xF658
- Ramp 1..8 real → X0 = 0x2400 + j0; X1..X7 identical to the previous case.
- Complex ramp (1+1j)..(8+8j) → X0 = 0x2400 + j0x2400; X4 = 0xFC00 + j0xFC00.
- All eight inputs 0x7F00 + j0 → X0 real = 0x7FFF with FFT_SATURATE_EN, 0xF800 without; X1..X7 = 0.
- Control corners:
  - write pulse during BUSY with different data → results match the originally captured samples.
  - Reset at cycle 30 of BUSY → ready stays 0, outputs return to 0.
  - Deassert then reassert start in DONE → ready drops, then rises 64 cycles after relaunch.
